rvfi_commit_buffer: RTL and testbench

RVFI_COMMIT_BUFFER -- requirements
Module: rvfi_commit_buffer

---
 rtl/rvfi_commit_buffer.sv | 119 +++++++++++
 tb/tb_rvfi_commit_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_commit_buffer.sv
// rvfi_commit_buffer: decouples ROB retirement from the RVFI port, numbers each
// commit and raises a sticky halt on a self-branch or a same-PC livelock.
module rvfi_commit_buffer #(
    parameter int DEPTH      = 8,
    parameter int LOOP_LIMIT = 2047
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [340:0] in_pkt,
    output logic         commit,
    output logic [63:0]  order,
    output logic [31:0]  rvfi_inst,
    output logic [31:0]  rvfi_pc_rdata,
    output logic [31:0]  rvfi_pc_wdata,
    output logic [4:0]   rvfi_rs1_addr,
    output logic [4:0]   rvfi_rs2_addr,
    output logic [31:0]  rvfi_rs1_rdata,
    output logic [31:0]  rvfi_rs2_rdata,
    output logic         rvfi_load_regfile,
    output logic [4:0]   rvfi_rd_addr,
    output logic [31:0]  rvfi_rd_wdata,
    output logic [31:0]  rvfi_mem_addr,
    output logic [3:0]   rvfi_mem_rmask,
    output logic [3:0]   rvfi_mem_wmask,
    output logic [31:0]  rvfi_mem_rdata,
    output logic [31:0]  rvfi_mem_wdata,
    output logic         rvfi_trap,
    output logic         halt,
    output logic         overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 313;
    localparam logic [10:0] LIM = 11'(LOOP_LIMIT);
    typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] pkt_q, pkt_d, head;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [63:0]   seq_q, seq_d, order_q, order_d;
    logic [31:0]   prev_pc_q, prev_pc_d, head_inst, head_pc, head_npc;
    logic [10:0]   same_q, same_d;
    logic          commit_q, commit_d, halt_q, halt_d, ovf_q, ovf_d, sync_q;
    logic          full, empty, push, pop, trig;
    logic          unused_pad;

    // Payload is everything above the low pad bits of in_pkt.
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign head_inst  = head[312:281];
    assign head_pc    = head[280:249];
    assign head_npc   = head[248:217];
    assign empty      = wr_ptr_q == rd_ptr_q;
    assign full       = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign in_ready   = sync_q & ~full & ~halt_q;
    assign push       = in_valid & in_ready;
    assign pop        = ~empty & ~halt_q;
    assign unused_pad = ^in_pkt[27:0];

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        pkt_d     = pop ? head : pkt_q;
        commit_d  = pop;
        order_d   = pop ? seq_q : order_q;
        seq_d     = seq_q + {63'd0, pop};
        prev_pc_d = pop ? head_pc : prev_pc_q;
        same_d    = !pop ? same_q : head_pc != prev_pc_q ? 11'd0 : same_q == LIM ? same_q : same_q + 11'd1;
        trig      = pop && ((head_inst == 32'h0000_0063 && head_npc == head_pc) || same_d == LIM);
        state_d   = state_q == RUN ? (trig ? HALTING : RUN) : HALTED;
        halt_d    = state_d != RUN;
        ovf_d     = ovf_q | (in_valid & full & ~halt_q);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_pkt[340:28];
    end

    // sync_q releases in_ready one edge after reset deassertion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_q     <= '0;
            commit_q  <= 1'b0;
            order_q   <= '0;
            seq_q     <= '0;
            prev_pc_q <= 32'h0000_0060;
            same_q    <= '0;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_q     <= pkt_d;
            commit_q  <= commit_d;
            order_q   <= order_d;
            seq_q     <= seq_d;
            prev_pc_q <= prev_pc_d;
            same_q    <= same_d;
            halt_q    <= halt_d;
            ovf_q     <= ovf_d;
            sync_q    <= 1'b1;
        end
    end

    assign {rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
            rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_load_regfile, rvfi_rd_addr, rvfi_rd_wdata,
            rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
            rvfi_trap} = pkt_q;
    assign commit       = commit_q;
    assign order        = order_q;
    assign halt         = halt_q;
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_rvfi_commit_buffer.sv
// tb_rvfi_commit_buffer: directed stimulus against a queue-based retirement model,
// compared every cycle, plus hand-computed literal expectations.
module tb_rvfi_commit_buffer;
    localparam int DEPTH = 4;
    localparam int LIM   = 4;

    typedef struct packed {
        logic [31:0] inst, pc_rdata, pc_wdata;
        logic [4:0]  rs1_addr, rs2_addr;
        logic [31:0] rs1_rdata, rs2_rdata;
        logic        load_regfile;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata, mem_addr;
        logic [3:0]  mem_rmask, mem_wmask;
        logic [31:0] mem_rdata, mem_wdata;
        logic        trap;
    } rec_t;

    logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
    logic [340:0] in_pkt = '0;
    logic         in_ready, commit, halt, overflow_err;
    logic [63:0]  order;
    logic [31:0]  rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
    logic [31:0]  rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [4:0]   rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]   rvfi_mem_rmask, rvfi_mem_wmask;
    logic         rvfi_load_regfile, rvfi_trap;
    logic [312:0] dut_vec;
    int           n_chk = 0, n_fail = 0;
    rec_t         cur = '0;

    rec_t        q[$];
    rec_t        m_pkt = '0, m_e = '0;
    logic        m_commit = 0, m_halt = 0, m_ovf = 0, m_started = 0, m_pop = 0, m_push = 0;
    logic [63:0] m_order = '0, m_n = '0;
    logic [31:0] m_last = 32'h60;
    int          m_rep = 0;

    rvfi_commit_buffer #(.DEPTH(DEPTH), .LOOP_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
        .commit(commit), .order(order),
        .rvfi_inst(rvfi_inst), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_load_regfile(rvfi_load_regfile), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_trap(rvfi_trap), .halt(halt), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    assign dut_vec = {rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
                      rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_load_regfile, rvfi_rd_addr, rvfi_rd_wdata,
                      rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
                      rvfi_trap};

    task automatic chk(input string name, input logic [312:0] act, input logic [312:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pcw);
        logic [319:0] b = '0;
        rec_t r;
        for (int i = 0; i < 10; i++) b = {b[287:0], 32'($urandom)};
        r = b[312:0];
        r.inst = inst;
        r.pc_rdata = pc;
        r.pc_wdata = pcw;
        return r;
    endfunction

    task automatic drive(input logic v, input rec_t r);
        in_valid = v;
        cur = r;
        in_pkt = {r, 28'($urandom)};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        in_valid = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    // Retirement model: a queue drained one entry per cycle unless halted.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            q.delete();
            m_pkt = '0; m_commit = 0; m_halt = 0; m_ovf = 0; m_started = 0;
            m_order = '0; m_n = '0; m_last = 32'h60; m_rep = 0;
        end else begin
            m_pop  = q.size() != 0 && !m_halt;
            m_push = in_valid && m_started && q.size() < DEPTH && !m_halt;
            if (in_valid && q.size() >= DEPTH && !m_halt) m_ovf = 1;
            m_commit = m_pop;
            if (m_pop) begin
                m_e = q.pop_front();
                m_pkt = m_e;
                m_order = m_n;
                m_n = m_n + 1;
                m_rep = (m_e.pc_rdata == m_last) ? (m_rep < LIM ? m_rep + 1 : m_rep) : 0;
                m_last = m_e.pc_rdata;
                if ((m_e.inst == 32'h63 && m_e.pc_wdata == m_e.pc_rdata) || m_rep == LIM) m_halt = 1;
            end
            if (m_push) q.push_back(cur);
            m_started = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("commit", commit, m_commit);
        chk("halt", halt, m_halt);
        chk("in_ready", in_ready, m_started && q.size() < DEPTH && !m_halt);
        chk("overflow_err", overflow_err, m_ovf);
        chk("order", order, m_order);
        chk("rvfi", dut_vec, m_pkt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_commit", commit, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_halt", halt, 0);
        chk("rst_order", order, 0);
        chk("rst_rvfi", dut_vec, 0);
        rst = 1;
        drive(0, '0);
        chk("sync_ready", in_ready, 1);

        drive(1, mk(32'h13, 32'h60, 32'h64));
        chk("single_lat1", commit, 0);
        drive(0, '0);
        chk("single_commit", commit, 1);
        chk("single_order", order, 0);
        chk("single_pc", rvfi_pc_rdata, 32'h60);
        drive(0, '0);
        chk("single_idle", commit, 0);

        for (int i = 0; i < 10; i++) begin
            drive(1, mk(32'h13, 32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i)));
            chk("burst_ready", in_ready, 1);
            if (i > 0) begin
                chk("burst_commit", commit, 1);
                chk("burst_order", order, 64'(i));
                chk("burst_pc", rvfi_pc_rdata, 32'h200 + 32'(4 * (i - 1)));
            end
        end
        drive(0, '0);
        chk("burst_last", order, 10);
        chk("burst_ovf", overflow_err, 0);

        drive(1, mk(32'h63, 32'h80, 32'h80));
        chk("loop_pre", commit, 0);
        drive(1, mk(32'h13, 32'h84, 32'h88));
        chk("loop_commit", commit, 1);
        chk("loop_halt", halt, 1);
        chk("loop_pc", rvfi_pc_rdata, 32'h80);
        chk("loop_ready", in_ready, 0);
        repeat (3) drive(1, mk(32'h13, 32'h90, 32'h94));
        chk("halted_commit", commit, 0);
        chk("halted_halt", halt, 1);

        do_reset();
        drive(0, '0);
        drive(1, mk(32'h13, 32'h400, 32'h404));
        drive(1, mk(32'h13, 32'h404, 32'h408));
        chk("mid_commit", commit, 1);
        rst = 0;
        in_valid = 0;
        #1;
        chk("mid_rst_commit", commit, 0);
        chk("mid_rst_order", order, 0);
        chk("mid_rst_rvfi", dut_vec, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_halt", halt, 0);
        @(posedge clk);
        #1;
        rst = 1;
        drive(0, '0);
        chk("post_ready", in_ready, 1);
        chk("post_nocommit", commit, 0);
        drive(1, mk(32'h13, 32'h300, 32'h304));
        drive(0, '0);
        chk("post_commit", commit, 1);
        chk("post_order", order, 0);
        chk("post_pc", rvfi_pc_rdata, 32'h300);

        for (int i = 0; i < 5; i++) drive(1, mk(32'h13, 32'h100, 32'h104));
        chk("same4_order", order, 4);
        chk("same4_halt", halt, 0);
        drive(1, mk(32'h13, 32'h500, 32'h504));
        chk("same5_commit", commit, 1);
        chk("same5_order", order, 5);
        chk("same5_halt", halt, 1);
        chk("same5_ready", in_ready, 0);
        repeat (2) drive(1, mk(32'h13, 32'h600, 32'h604));
        chk("same_halted", commit, 0);
        drive(0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
